// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the issue-side hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned DEF_MUL_LAT  = 4;
  localparam int unsigned LOAD_USE_LAT = 1;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : hazard_scoreboard_pkg

// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the scoreboard: decoded instruction fields in, hazard status out.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic     id_valid_i;
  reg_idx_t id_rs_i;
  reg_idx_t id_rt_i;
  logic     id_use_rs_i;
  logic     id_use_rt_i;
  reg_idx_t id_rd_i;
  logic     id_regwrite_i;
  logic     id_memread_i;
  logic     id_mul_i;
  logic     flush_i;
  logic     stall_o;
  logic     busy_o;
  logic [31:0] pending_o;

  // ID/decode side drives the instruction fields.
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_rd_i,
           id_regwrite_i, id_memread_i, id_mul_i, flush_i,
    input  stall_o, busy_o, pending_o
  );

  // Scoreboard side.
  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_rd_i,
           id_regwrite_i, id_memread_i, id_mul_i, flush_i,
    output stall_o, busy_o, pending_o
  );

endinterface : hazard_scoreboard_if

// File: rtl/hazard_scoreboard_counter.sv
// Loadable down-counter that saturates at zero; a load takes precedence over the decrement.
module sb_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load, else count down towards zero and stay there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign count_o = cnt_q;

endmodule : sb_counter

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: per-register "cycles until forwardable" counters plus a
// multiplier occupancy counter, with RAW/WAW/structural stall detection for the ID stage.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,  // 1..15
  parameter int unsigned CNT_W   = 4             // 2**CNT_W must exceed MUL_LAT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_scoreboard_if.slave  id_if
);

  localparam logic [CNT_W-1:0] MulLatVal  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] LoadLatVal = CNT_W'(LOAD_USE_LAT);

  logic [CNT_W-1:0] reg_cnt [1:31];
  logic [CNT_W-1:0] mul_cnt;
  logic [31:1]      load_en;
  logic [CNT_W-1:0] rd_val;
  logic [31:0]      pending;
  logic             raw_hz, waw_hz, str_hz, stall, accept, mul_load;

  for (genvar r = 1; r < 32; r++) begin : g_reg_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (load_en[r]),
      .load_val_i (rd_val),
      .count_o    (reg_cnt[r])
    );
  end

  sb_counter #(.CNT_W(CNT_W)) u_mul_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (mul_load),
    .load_val_i (MulLatVal),
    .count_o    (mul_cnt)
  );

  // Pending vector; r0 is hard-wired idle so it can never raise a hazard.
  always_comb begin
    pending = '0;
    for (int r = 1; r < 32; r++) begin
      pending[r] = (reg_cnt[r] != '0);
    end
  end

  // Hazard comparators; stall is purely combinational from state and ID fields.
  always_comb begin
    raw_hz = (id_if.id_use_rs_i && (id_if.id_rs_i != REG_ZERO) && pending[id_if.id_rs_i]) ||
             (id_if.id_use_rt_i && (id_if.id_rt_i != REG_ZERO) && pending[id_if.id_rt_i]);
    waw_hz = id_if.id_regwrite_i && (id_if.id_rd_i != REG_ZERO) && pending[id_if.id_rd_i];
    str_hz = id_if.id_mul_i && (mul_cnt != '0);
    stall  = id_if.id_valid_i && (raw_hz || waw_hz || str_hz);
    accept = id_if.id_valid_i && !stall && !id_if.flush_i;
  end

  // Accept logic; a load beats a multiply if both are flagged.
  always_comb begin
    rd_val = '0;
    if (id_if.id_memread_i) begin
      rd_val = LoadLatVal;
    end else if (id_if.id_mul_i) begin
      rd_val = MulLatVal;
    end
    mul_load = accept && id_if.id_mul_i;
    load_en  = '0;
    for (int r = 1; r < 32; r++) begin
      load_en[r] = accept && id_if.id_regwrite_i && (id_if.id_rd_i == REG_IDX_W'(r));
    end
  end

  assign id_if.stall_o   = stall;
  assign id_if.pending_o = pending;
  assign id_if.busy_o    = (pending != '0) || (mul_cnt != '0);

endmodule : hazard_scoreboard

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side hazard controller for the 5-stage pipelined CPU: records every register-writing instruction leaving ID and tracks how many cycles remain before its result can be picked up by EX-stage operand forwarding. Asserts a stall whenever an instruction in ID reads or rewrites a register whose producer is not yet forwardable:
- load-use: one bubble;
- multi-cycle multiply: MUL_LAT bubbles.

Sits beside the ID/EX pipeline register and drives PC/IF-ID hold and bubble insertion.

## Interface
- MUL_LAT, 4, cycles a multiply result is not forwardable after issue (1..15)
- CNT_W, 4, per-register counter width; must satisfy 2^CNT_W > MUL_LAT
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-high
- id_valid_i  input  1  ID holds a real instruction
- id_rs_i, id_rt_i  input  5 each  ID source register numbers
- id_use_rs_i, id_use_rt_i  input  1 each  source actually read
- id_rd_i  input  5  ID destination register
- id_regwrite_i  input  1  ID instruction writes id_rd_i
- id_memread_i  input  1  ID instruction is a load
- id_mul_i  input  1  ID instruction uses the multiplier
- flush_i  input  1  branch taken; ID instruction is squashed
- stall_o  output  1  hold PC and IF/ID; insert bubble into ID/EX
- busy_o  output  1  any counter non-zero
- pending_o  output  32  bit r = cnt[r] != 0

## Operation
- State:
  - cnt[1..31], CNT_W bits each; cnt[0] is constant 0;
  - mul_cnt, CNT_W bits, counts remaining multiplier occupancy.
- Hazard terms, all gated by id_valid_i:
  - RAW: use_rs & rs!=0 & cnt[rs]!=0, or the same for rt.
  - WAW: id_regwrite_i & rd!=0 & cnt[rd]!=0.
  - Structural: id_mul_i & mul_cnt!=0.
- stall_o = RAW | WAW | structural, combinational from current state and ID inputs.
- An instruction is accepted when id_valid_i & ~stall_o & ~flush_i.
- On accept with id_regwrite_i & rd!=0, cnt[rd] loads:
  - 1 if id_memread_i;
  - MUL_LAT if id_mul_i;
  - otherwise 0, since an ALU result forwards next cycle.
- On accept with id_mul_i, mul_cnt loads MUL_LAT.
- Every other non-zero counter decrements by 1 each cycle, saturating at 0.
- The register being loaded does not also decrement in that cycle. No conflict arises because WAW stalls guarantee its counter is 0 before load.
- flush_i squashes only the ID instruction: nothing is recorded. Counters of instructions already past ID keep counting.
- stall_o is still computed during flush_i. The top level gives flush priority.
- Writes to r0 are never recorded; reads of r0 never stall.
- id_memread_i & id_mul_i together is illegal. If it occurs, the load path wins (value 1).

## Timing
- Reset: all counters 0, so stall_o=0, busy_o=0, pending_o=0. Reset mid-stall clears stall_o in the cycle after the reset edge.
- Load accepted at cycle t → dependent instruction in ID at t+1 sees stall_o=1 → it proceeds at t+2, exactly one bubble.
- Multiply accepted at t → dependent stalls cycles t+1..t+MUL_LAT → it proceeds at t+MUL_LAT+1.
- A back-to-back multiply sees the same structural stall window.
- No added latency on stall_o: it is purely combinational from registered state and inputs.
- While stalled, the ID inputs are held by the upstream stall. The block must not record anything until the stall drops.

## Structure
- Shared package/header `pipe_defs`: REG_ZERO (5'd0), LOAD_USE_LAT (1), default MUL_LAT, register-index width (5).
- One natural sub-module: `sb_counter`, a loadable saturating down-counter with CNT_W bits, instantiated 31 times plus once for mul_cnt.
- The top level holds the hazard comparators and the accept logic.

## Test plan
- Reset asserted with cnt[5]=3 → next cycle pending_o=0, stall_o=0, busy_o=0.
- lw rd=8, then add rs=8 → stall_o=1 for exactly 1 cycle; the add is accepted on the 2nd cycle; pending_o[8] clears together with the stall.
- mul rd=9 with MUL_LAT=4, then sub rt=9 → stall_o high for 4 cycles; the sub is accepted on the 5th.
- mul rd=9, then an independent mul rd=10 → 4-cycle structural stall; then pending_o[10]=1 for 4 cycles.
- lw rd=0, then add rs=0 → no stall, pending_o=0.
- lw rd=8 with flush_i=1 in the same cycle → nothing recorded; next-cycle add rs=8 → stall_o=0.
- Extra check: lw rd=8, then lw rd=8 the next cycle → WAW stall for 1 cycle.
